// File: rtl/veerwolf_wb_pkg.sv
// rtl/veerwolf_wb_pkg.sv - shared wishbone types and widths for the VeeRwolf peripheral fabric
package veerwolf_wb_pkg;

  typedef enum logic [1:0] {
    WBI_IDLE,
    WBI_CYCLE,
    WBI_RESP
  } wbi_state_t;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  function automatic logic [WB_DW-1:0] wbi_ack_data(input logic we, input logic [WB_DW-1:0] rdt);
    return we ? '0 : rdt;
  endfunction

endpackage

// File: rtl/veerwolf_wb_initiator_if.sv
// rtl/veerwolf_wb_initiator_if.sv - command, response and wishbone signals of the initiator
interface veerwolf_wb_initiator_if #(
  parameter int ADR_W = 8
) ();
  import veerwolf_wb_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ADR_W-1:0]     req_adr;
  logic [WB_DW-1:0]     req_dat;
  logic [WB_SELW-1:0]   req_sel;
  logic                 req_we;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WB_DW-1:0]     rsp_dat;
  logic                 rsp_err;
  logic                 busy;

  logic [ADR_W-1:0]     wb_adr;
  logic [WB_DW-1:0]     wb_dat;
  logic [WB_SELW-1:0]   wb_sel;
  logic                 wb_we;
  logic                 wb_cyc;
  logic                 wb_stb;
  logic [WB_DW-1:0]     wb_rdt;
  logic                 wb_ack;
  logic                 wb_err;

  modport master (
    input  req_valid, req_adr, req_dat, req_sel, req_we, rsp_ready,
    input  wb_rdt, wb_ack, wb_err,
    output req_ready, rsp_valid, rsp_dat, rsp_err, busy,
    output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb
  );

  modport slave (
    output req_valid, req_adr, req_dat, req_sel, req_we, rsp_ready,
    output wb_rdt, wb_ack, wb_err,
    input  req_ready, rsp_valid, rsp_dat, rsp_err, busy,
    input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb
  );

endinterface

// File: rtl/wbi_timeout_timer.sv
// rtl/wbi_timeout_timer.sv - saturating strobe-cycle counter that flags the abort edge
module wbi_timeout_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt <= '0;
    end else if (i_enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the strobe edges already seen, so the edge that would make it LIMIT is the abort edge
  assign o_expired = (TIMEOUT_CYC != 0) && i_enable && (cnt == LIMIT - CW'(1));

endmodule

// File: rtl/veerwolf_wb_initiator.sv
// rtl/veerwolf_wb_initiator.sv - single-transfer wishbone classic master with response channel and timeout
module veerwolf_wb_initiator
  import veerwolf_wb_pkg::*;
#(
  parameter int               ADR_W       = 8,
  parameter int               TIMEOUT_CYC = 255,
  parameter logic [WB_DW-1:0] ERR_RDATA   = 32'hDEADBEEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  veerwolf_wb_initiator_if.master   bus
);

  wbi_state_t state;
  logic       accept;
  logic       expired;

  assign accept = (state == WBI_IDLE) && bus.req_valid && bus.req_ready;

  wbi_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (accept),
    .i_enable  (state == WBI_CYCLE),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= WBI_IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dat   <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.wb_adr    <= '0;
      bus.wb_dat    <= '0;
      bus.wb_sel    <= '0;
      bus.wb_we     <= 1'b0;
      bus.wb_cyc    <= 1'b0;
      bus.wb_stb    <= 1'b0;
    end else begin
      case (state)
        WBI_IDLE: begin
          if (accept) begin
            bus.wb_adr    <= ADR_W'(bus.req_adr);
            bus.wb_dat    <= bus.req_dat;
            bus.wb_sel    <= bus.req_sel;
            bus.wb_we     <= bus.req_we;
            bus.wb_cyc    <= 1'b1;
            bus.wb_stb    <= 1'b1;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= WBI_CYCLE;
          end
        end
        WBI_CYCLE: begin
          // priority: slave error, then ack, then timeout (a late ack still beats the abort)
          if (bus.wb_err || bus.wb_ack || expired) begin
            bus.wb_cyc    <= 1'b0;
            bus.wb_stb    <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= WBI_RESP;
            if (bus.wb_ack && !bus.wb_err) begin
              bus.rsp_dat <= wbi_ack_data(bus.wb_we, bus.wb_rdt);
              bus.rsp_err <= 1'b0;
            end else begin
              bus.rsp_dat <= ERR_RDATA;
              bus.rsp_err <= 1'b1;
            end
          end
        end
        WBI_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= WBI_IDLE;
          end
        end
        default: begin
          state         <= WBI_IDLE;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
